alu_share_ctrl: RTL and testbench

//   Shares one instance of the 32-bit combinational ALU between NUM_REQ requesters.

---
 rtl/alu_share_ctrl_pkg.sv | 29 ++
 rtl/alu_share_ctrl_if.sv | 28 ++
 rtl/alu_share_ctrl_alu.sv | 47 ++++
 rtl/alu_share_ctrl_rr_arbiter.sv | 40 ++++
 rtl/alu_share_ctrl.sv | 132 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 219 +++++++++++++++++++++
 6 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the shared-ALU controller: ALU function codes and FSM states.
package alu_share_ctrl_pkg;

  // ALU function codes
  localparam logic [5:0] FunAdd   = 6'b000000;
  localparam logic [5:0] FunSub   = 6'b000001;
  localparam logic [5:0] FunAnd   = 6'b011000;
  localparam logic [5:0] FunOr    = 6'b011110;
  localparam logic [5:0] FunXor   = 6'b010110;
  localparam logic [5:0] FunNor   = 6'b010001;
  localparam logic [5:0] FunPassA = 6'b011010;
  localparam logic [5:0] FunSll   = 6'b100000;
  localparam logic [5:0] FunSrl   = 6'b100001;
  localparam logic [5:0] FunSra   = 6'b100011;
  localparam logic [5:0] FunEq    = 6'b110011;
  localparam logic [5:0] FunNeq   = 6'b110001;
  localparam logic [5:0] FunLt    = 6'b110101;
  localparam logic [5:0] FunLez   = 6'b111101;
  localparam logic [5:0] FunLtz   = 6'b111011;
  localparam logic [5:0] FunGtz   = 6'b111111;

  // Controller FSM states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bus between the issue stages (master) and the shared-ALU controller (slave).
interface alu_share_ctrl_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*6-1:0]  req_fun;
  logic [NUM_REQ-1:0]    req_sign;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_fun, req_sign, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_fun, req_sign, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/alu_share_ctrl_alu.sv
// 32-bit combinational ALU. Shifts move operand B by A[4:0]; compares return 0/1 in bit 0.
module alu_share_ctrl_alu
  import alu_share_ctrl_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [5:0]  i_fun,
  input  logic        i_sign,
  output logic [31:0] o_z
);

  logic w_eq;
  logic w_lt;
  logic w_a_neg;
  logic w_a_zero;

  assign w_eq     = (i_a == i_b);
  assign w_lt     = i_sign ? ($signed(i_a) < $signed(i_b)) : (i_a < i_b);
  // Compares against zero always treat A as two's complement.
  assign w_a_neg  = i_a[31];
  assign w_a_zero = (i_a == 32'd0);

  // Function decode; unknown codes yield zero.
  always_comb begin
    o_z = '0;
    case (i_fun)
      FunAdd:   o_z = i_a + i_b;
      FunSub:   o_z = i_a - i_b;
      FunAnd:   o_z = i_a & i_b;
      FunOr:    o_z = i_a | i_b;
      FunXor:   o_z = i_a ^ i_b;
      FunNor:   o_z = ~(i_a | i_b);
      FunPassA: o_z = i_a;
      FunSll:   o_z = i_b << i_a[4:0];
      FunSrl:   o_z = i_b >> i_a[4:0];
      FunSra:   o_z = $unsigned($signed(i_b) >>> i_a[4:0]);
      FunEq:    o_z = {31'd0, w_eq};
      FunNeq:   o_z = {31'd0, !w_eq};
      FunLt:    o_z = {31'd0, w_lt};
      FunLez:   o_z = {31'd0, w_a_neg | w_a_zero};
      FunLtz:   o_z = {31'd0, w_a_neg};
      FunGtz:   o_z = {31'd0, !w_a_neg && !w_a_zero};
      default:  o_z = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: priority starts at the requester after the last grant.
module alu_share_ctrl_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last_grant,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx
);

  int unsigned w_dist;
  int unsigned w_best;
  int unsigned w_win;

  // Pick the valid requester with the smallest distance past the last grant.
  always_comb begin
    w_dist = 0;
    w_best = NUM_REQ;
    w_win  = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - 1 - 32'(i_last_grant)) % NUM_REQ;
      if (i_enable && i_req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_win  = i;
      end
    end
  end

  // Expand the winner into a one-hot grant.
  always_comb begin
    o_grant = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      o_grant[i] = (w_best < NUM_REQ) && (w_win == i);
    end
    o_grant_idx = w_win[ID_W-1:0];
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between NUM_REQ issue stages: accept (IDLE), compute (EXEC), hold result (RESP).
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input logic               clk,
  input logic               reset,
  alu_share_ctrl_if.slave   io_bus
);

  state_e              r_state;
  state_e              w_state_next;
  logic [31:0]         r_a;
  logic [31:0]         r_b;
  logic [5:0]          r_fun;
  logic                r_sign;
  logic [ID_W-1:0]     r_id;
  logic [ID_W-1:0]     r_last_grant;
  logic [31:0]         r_rsp_data;
  logic [ID_W-1:0]     r_rsp_id;

  logic                w_arb_en;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_grant_idx;
  logic                w_accept;
  logic [31:0]         w_sel_a;
  logic [31:0]         w_sel_b;
  logic [5:0]          w_sel_fun;
  logic                w_sel_sign;
  logic [31:0]         w_alu_z;

  // No grant while reset is held so nothing is accepted in that cycle.
  assign w_arb_en = (r_state == StIdle) && !reset;
  assign w_accept = |(io_bus.req_valid & w_grant);

  alu_share_ctrl_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req        (io_bus.req_valid),
    .i_last_grant (r_last_grant),
    .i_enable     (w_arb_en),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx)
  );

  // Operand mux selected by the one-hot grant.
  always_comb begin
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_sel_fun  = '0;
    w_sel_sign = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a    = io_bus.req_a[i*32 +: 32];
        w_sel_b    = io_bus.req_b[i*32 +: 32];
        w_sel_fun  = io_bus.req_fun[i*6 +: 6];
        w_sel_sign = io_bus.req_sign[i];
      end
    end
  end

  // The ALU sees only latched operands, never the live request bus.
  alu_share_ctrl_alu u_alu (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_fun  (r_fun),
    .i_sign (r_sign),
    .o_z    (w_alu_z)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_state_next = StExec;
      StExec:  w_state_next = StResp;
      StResp:  if (io_bus.rsp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: ready only for the winner in IDLE, valid throughout RESP.
  always_comb begin
    io_bus.req_ready = '0;
    io_bus.rsp_valid = 1'b0;
    if (r_state == StIdle) io_bus.req_ready = w_grant;
    if (r_state == StResp) io_bus.rsp_valid = 1'b1;
  end

  // Operand latch on accept, result capture at end of EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a          <= '0;
      r_b          <= '0;
      r_fun        <= FunAdd;
      r_sign       <= 1'b1;
      r_id         <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_rsp_data   <= '0;
      r_rsp_id     <= '0;
    end else begin
      if (w_accept) begin
        r_a          <= w_sel_a;
        r_b          <= w_sel_b;
        r_fun        <= w_sel_fun;
        r_sign       <= w_sel_sign;
        r_id         <= w_grant_idx;
        r_last_grant <= w_grant_idx;
      end
      if (r_state == StExec) begin
        r_rsp_data <= w_alu_z;
        r_rsp_id   <= r_id;
      end
    end
  end

  assign io_bus.rsp_data = r_rsp_data;
  assign io_bus.rsp_id   = r_rsp_id;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a response scoreboard.
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  localparam int unsigned NReq = 2;
  localparam int unsigned IdW  = 1;

  typedef struct {
    logic [IdW-1:0] id;
    logic [31:0]    data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int unsigned t0;
  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];

  alu_share_ctrl_if #(.NUM_REQ(NReq), .ID_W(IdW)) bus ();

  alu_share_ctrl #(.NUM_REQ(NReq), .ID_W(IdW)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [5:0] fun,
                         input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.req_valid[i]        = v;
    bus.req_fun[i*6 +: 6]   = fun;
    bus.req_a[i*32 +: 32]   = a;
    bus.req_b[i*32 +: 32]   = b;
    bus.req_sign[i]         = s;
  endtask

  task automatic push(input logic [IdW-1:0] id, input logic [31:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    sb.push_back(e);
  endtask

  // Wait (bounded) for a response, compare it with the scoreboard head, then accept it.
  task automatic get_rsp(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    if (bus.rsp_valid === 1'b1) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL %s_unexpected observed=rsp expected=none", tag);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, "_data"}, bus.rsp_data, e.data);
        chk({tag, "_id"}, 32'(bus.rsp_id), 32'(e.id));
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
    end
  endtask

  // Issue one op from requester i alone, expect it granted, then collect the response.
  task automatic issue(input int i, input logic [5:0] fun, input logic [31:0] a,
                       input logic [31:0] b, input logic s, input logic [31:0] exp_d,
                       input string tag);
    set_req(i, 1'b1, fun, a, b, s);
    #1;
    chk({tag, "_grant"}, 32'(bus.req_ready), 32'd1 << i);
    push(IdW'(i), exp_d);
    @(negedge clk);
    bus.req_valid[i] = 1'b0;
    get_rsp(tag);
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_fun   = '0;
    bus.req_sign  = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single requester ADD, latency of two cycles from accept to rsp_valid
    set_req(0, 1'b1, FunAdd, 32'd15, 32'd12, 1'b1);
    #1;
    chk("t1_grant", 32'(bus.req_ready), 32'd1);
    push(1'b0, 32'd27);
    t0 = cyc;
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    #1;
    chk("t1_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t1_exec_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("t1_rsp_valid_n2", 32'(bus.rsp_valid), 32'd1);
    chk("t1_latency", cyc - t0, 32'd2);
    get_rsp("t1");

    // Both requesters valid from reset: alternation 0,1,0,1
    reset = 1'b1;
    set_req(0, 1'b1, FunSub, 32'd15, 32'd12, 1'b0);
    set_req(1, 1'b1, FunXor, 32'd15, 32'd12, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_grant%0d", k), 32'(bus.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      push(IdW'(k % 2), 32'd3);
      get_rsp($sformatf("t2_op%0d", k));
      #1;
    end
    bus.req_valid = '0;

    // Back-pressure: result held stable, no new accepts
    set_req(0, 1'b1, FunNor, 32'd15, 32'd12, 1'b0);
    #1;
    chk("t3_grant", 32'(bus.req_ready), 32'd1);
    push(1'b0, 32'hFFFF_FFF0);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    set_req(1, 1'b1, FunAdd, 32'd1, 32'd1, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_hold_valid%0d", k), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("t3_hold_data%0d", k), bus.rsp_data, 32'hFFFF_FFF0);
      chk($sformatf("t3_hold_ready%0d", k), 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.req_valid[1] = 1'b0;
    get_rsp("t3");

    // Signed/unsigned compare, shifts and a few more functions
    issue(0, FunLt, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd1, "t4_ltu");
    issue(0, FunLt, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'd0, "t4_lts");
    issue(0, FunSll, 32'd4, 32'd1, 1'b0, 32'd16, "t4_sll");
    issue(0, FunEq, 32'd7, 32'd7, 1'b0, 32'd1, "t4_eq");
    issue(1, FunPassA, 32'h1234, 32'd9, 1'b0, 32'h1234, "t4_passa");
    issue(0, FunSra, 32'd3, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, "t4_sra");

    // Reset during EXEC discards the op; req0 regains first priority
    set_req(0, 1'b1, FunAdd, 32'd1, 32'd2, 1'b0);
    set_req(1, 1'b1, FunAdd, 32'd3, 32'd4, 1'b0);
    #1;
    chk("t5_pre_grant", 32'(bus.req_ready), 32'd2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5_rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("t5_rst_rsp_data", bus.rsp_data, 32'd0);
    chk("t5_rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    reset = 1'b0;
    #1;
    chk("t5_post_grant", 32'(bus.req_ready), 32'd1);
    push(1'b0, 32'd3);
    @(negedge clk);
    bus.req_valid = '0;
    get_rsp("t5");

    // Requester 1 pulses valid only while req0 is in EXEC: never served
    set_req(0, 1'b1, FunAdd, 32'd5, 32'd6, 1'b0);
    #1;
    chk("t6_grant", 32'(bus.req_ready), 32'd1);
    push(1'b0, 32'd11);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    set_req(1, 1'b1, FunAdd, 32'd7, 32'd7, 1'b0);
    #1;
    chk("t6_exec_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    get_rsp("t6");
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t6_idle_valid%0d", k), 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
